// File: rtl/mult_wb_pkg.sv
// mult_wb_pkg: shared constants and FSM encoding for mult_wb_sequencer.
`default_nettype none

package mult_wb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  localparam int FLAGS_W   = 3;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_RSVD = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_LOW  = 2'd1,
    WR_HIGH = 2'd2
  } state_e;

endpackage : mult_wb_pkg

`default_nettype wire

// File: rtl/mult_wb_sequencer.sv
// mult_wb_sequencer: writes a captured multiplier product back to the register file as one or two bytes.
// Rev 1.0. Optional macro MULT_WB_PAIR_ALIGN_EN forces wide destinations onto an even register.
`default_nettype none

module mult_wb_sequencer
  import mult_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                wide,
  input  logic [ADDR_W-1:0]   dest_addr,
  input  logic [2*DATA_W-1:0] result_in,
  input  logic [FLAGS_W-1:0]  flags_in,
  input  logic                wb_ready,
  output logic                stall,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_data,
  output logic                flags_we,
  output logic [FLAGS_W-1:0]  flags_out,
  output logic                done
);

  state_e                state_q, state_d;
  logic                  wide_q, wide_d;
  logic [ADDR_W-1:0]     dest_q, dest_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic [FLAGS_W-1:0]    flags_q, flags_d;

  logic                  stall_q, stall_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]     rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]     rf_data_q, rf_data_d;
  logic                  flags_we_q, flags_we_d;
  logic [FLAGS_W-1:0]    flags_out_q, flags_out_d;
  logic                  done_q, done_d;

  logic                  write_done;
  logic [ADDR_W-1:0]     dest_capture;

  assign write_done = rf_we_q & wb_ready;

`ifdef MULT_WB_PAIR_ALIGN_EN
  assign dest_capture = wide ? {dest_addr[ADDR_W-1:1], 1'b0} : dest_addr;
`else
  assign dest_capture = dest_addr;
`endif

  always_comb begin
    state_d  = state_q;
    wide_d   = wide_q;
    dest_d   = dest_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WR_LOW;
          wide_d   = wide;
          dest_d   = dest_capture;
          result_d = result_in;
          flags_d  = flags_in;
        end
      end
      WR_LOW: begin
        if (write_done) begin
          if (wide_q) begin
            state_d = WR_HIGH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WR_HIGH: begin
        if (write_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Returning to IDLE drops the finished transaction so idle outputs read as zero.
    if (state_d == IDLE) begin
      wide_d   = 1'b0;
      dest_d   = '0;
      result_d = '0;
      flags_d  = '0;
    end

    stall_d     = (state_d != IDLE);
    rf_we_d     = (state_d != IDLE);
    flags_out_d = flags_d;
    flags_we_d  = (state_d == WR_HIGH) || ((state_d == WR_LOW) && !wide_d);

    case (state_d)
      WR_LOW: begin
        rf_addr_d = dest_d;
        rf_data_d = result_d[DATA_W-1:0];
      end
      WR_HIGH: begin
        rf_addr_d = dest_d + ADDR_W'(1);
        rf_data_d = result_d[2*DATA_W-1:DATA_W];
      end
      default: begin
        rf_addr_d = '0;
        rf_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wide_q      <= 1'b0;
      dest_q      <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      stall_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      flags_we_q  <= 1'b0;
      flags_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wide_q      <= wide_d;
      dest_q      <= dest_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      stall_q     <= stall_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      flags_we_q  <= flags_we_d;
      flags_out_q <= flags_out_d;
      done_q      <= done_d;
    end
  end

  assign stall     = stall_q;
  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign flags_we  = flags_we_q;
  assign flags_out = flags_out_q;
  assign done      = done_q;

endmodule : mult_wb_sequencer

`default_nettype wire
